// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Definitions shared by the ARM core's flag logic:
//   FLAG_W          width of the NZCV status word
//   N/Z/C/V_BIT     bit positions of each flag inside the status word
//   MASK_ALL        write mask for compare and arithmetic ops (all four flags)
//   MASK_NZC        write mask for logical ops with S (V is kept)
//   slot_state_t    state of the one-deep exception save slot
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int FLAG_W = 4;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  localparam logic [FLAG_W-1:0] MASK_ALL = 4'b1111;
  localparam logic [FLAG_W-1:0] MASK_NZC = 4'b1110;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_state_t;

endpackage : arm_pkg

// File: rtl/flag_merge.sv
// ---------------------------------------------------------------------------
// flag_merge
// Combinational masked merge of a flag word. Each output bit comes from
// new_flags where the mask bit is set and from base where it is clear.
// Ports:
//   base       current flag word
//   new_flags  candidate flag word
//   mask       per-bit select, 1 = take new_flags
//   merged     result
// ---------------------------------------------------------------------------
module flag_merge #(
  parameter int W = 4
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] new_flags,
  input  logic [W-1:0] mask,
  output logic [W-1:0] merged
);

  assign merged = (new_flags & mask) | (base & ~mask);

endmodule : flag_merge

// File: rtl/status_register.sv
// ---------------------------------------------------------------------------
// status_register
// Architectural NZCV register sitting in front of the condition-check stage.
// Captures ALU flags from flag-setting EXE instructions with per-flag write
// masking, holds across stalls and flushes, and keeps a one-deep save slot
// for exception entry/return.
//
// Save slot states:
//   state      | meaning
//   SLOT_EMPTY | no saved flags; restore only raises restore_err
//   SLOT_HELD  | slot holds flags from the last save; restore copies them back
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   alu_flags[3:0]   new flags from the ALU, {N,Z,C,V}
//   flag_mask[3:0]   per-flag write enable, same order
//   s_bit            EXE instruction sets flags
//   exe_valid        EXE holds a real instruction
//   stall            EXE frozen this cycle
//   flush            EXE instruction squashed this cycle
//   save             exception entry, live flags -> slot
//   restore          exception return, slot -> live flags
//   status[3:0]      registered live flags
//   condition_check  live flags with same-cycle EXE update bypassed in
//   carry_in         registered C flag for ADC/SBC/RSC
//   saved_valid      slot holds data
//   restore_err      one-cycle pulse after a restore against an empty slot
// ---------------------------------------------------------------------------
module status_register #(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              s_bit,
  input  logic              exe_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              save,
  input  logic              restore,
  output logic [FLAG_W-1:0] status,
  output logic [FLAG_W-1:0] condition_check,
  output logic              carry_in,
  output logic              saved_valid,
  output logic              restore_err
);

  import arm_pkg::slot_state_t;
  import arm_pkg::SLOT_EMPTY;
  import arm_pkg::SLOT_HELD;
  import arm_pkg::C_BIT;

  logic [FLAG_W-1:0] status_q;
  logic [FLAG_W-1:0] slot_q;
  slot_state_t       slot_state;
  logic              err_q;

  logic              upd;
  logic              restore_hit;
  logic [FLAG_W-1:0] upd_merged;
  logic [FLAG_W-1:0] upd_val;
  logic [FLAG_W-1:0] live_next;

  assign upd         = s_bit & exe_valid & ~stall & ~flush;
  assign restore_hit = restore & (slot_state == SLOT_HELD);

  flag_merge #(.W(FLAG_W)) u_upd_merge (
    .base      (status_q),
    .new_flags (alu_flags),
    .mask      (flag_mask),
    .merged    (upd_merged)
  );

  assign upd_val = upd ? upd_merged : status_q;

  // Restore overrides the whole word, so the same merge is reused with an
  // all-or-nothing mask; this gives restore priority over a same-cycle update.
  flag_merge #(.W(FLAG_W)) u_restore_merge (
    .base      (upd_val),
    .new_flags (slot_q),
    .mask      ({FLAG_W{restore_hit}}),
    .merged    (live_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q   <= '0;
      slot_q     <= '0;
      slot_state <= SLOT_EMPTY;
      err_q      <= 1'b0;
    end else begin
      status_q <= live_next;

      // Slot always captures the pre-update, pre-restore live value.
      if (save) begin
        slot_q <= status_q;
      end

      // save wins the state: HELD stays HELD on save+restore, EMPTY+save+restore
      // is a plain save without error.
      if (save) begin
        slot_state <= SLOT_HELD;
      end else if (restore) begin
        slot_state <= SLOT_EMPTY;
      end

      err_q <= restore & ~save & (slot_state == SLOT_EMPTY);
    end
  end

  assign status          = status_q;
  assign condition_check = upd_val;
  assign carry_in        = status_q[C_BIT];
  assign saved_valid     = (slot_state == SLOT_HELD);
  assign restore_err     = err_q;

endmodule : status_register
